// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int REG_W      = 5;
  localparam int WAIT_CNT_W = 8;
  localparam int PERF_CNT_W = 32;

  localparam logic [WAIT_CNT_W-1:0] DM_TIMEOUT_DEF = 8'd255;

  typedef enum logic {
    RUN     = 1'b0,
    DM_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_stall;
    logic exmem_stall;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EX writing a register that ID is about to read.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_MemRead,
  output logic             load_use
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit  = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit  = id_rs2_used && (id_rs2 == ex_rd);
  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = ex_MemRead && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller with DM wait FSM and sticky timeout.
// Define PIPE_HAZARD_PERF_CNT_EN to build the stall/flush perf counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [WAIT_CNT_W-1:0] DM_TIMEOUT = DM_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_W-1:0]      id_rs1,
  input  logic [REG_W-1:0]      id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_W-1:0]      ex_rd,
  input  logic                  ex_MemRead,
  input  logic                  ex_BranchTaken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  im_ready,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  idex_stall,
  output logic                  exmem_stall,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  memwb_flush,
  output logic                  dm_timeout,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
);

  logic  freeze, load_use;
  ctrl_t ctrl;

  assign freeze = mem_req && !mem_ready;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_MemRead  (ex_MemRead),
    .load_use    (load_use)
  );

  // Priority: reset bubbles > DM freeze > taken branch > load-use / IM wait
  always_comb begin
    ctrl = '0;
    if (rst) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.memwb_flush = 1'b1;
    end else if (freeze) begin
      ctrl.pc_stall    = 1'b1;
      ctrl.ifid_stall  = 1'b1;
      ctrl.idex_stall  = 1'b1;
      ctrl.exmem_stall = 1'b1;
      ctrl.memwb_flush = 1'b1;
    end else if (ex_BranchTaken) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
    end else begin
      if (load_use) begin
        ctrl.pc_stall   = 1'b1;
        ctrl.ifid_stall = 1'b1;
        ctrl.idex_flush = 1'b1;
      end
      // Holding IF/ID for the load-use retry keeps the fetched instruction
      if (!im_ready) begin
        ctrl.pc_stall   = 1'b1;
        ctrl.ifid_flush = !load_use;
      end
    end
  end

  assign pc_stall    = ctrl.pc_stall;
  assign ifid_stall  = ctrl.ifid_stall;
  assign idex_stall  = ctrl.idex_stall;
  assign exmem_stall = ctrl.exmem_stall;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign memwb_flush = ctrl.memwb_flush;

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  dm_timeout_q, dm_timeout_d;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    dm_timeout_d = dm_timeout_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = DM_WAIT;
          wait_cnt_d = '0;
        end
      end
      DM_WAIT: begin
        if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_d >= DM_TIMEOUT) dm_timeout_d = 1'b1;
        if (mem_ready) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      wait_cnt_q   <= '0;
      dm_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      dm_timeout_q <= dm_timeout_d;
    end
  end

  assign dm_timeout = dm_timeout_q;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic                  any_flush;

  assign any_flush = ctrl.ifid_flush || ctrl.idex_flush || ctrl.memwb_flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {{(PERF_CNT_W-1){1'b0}}, ctrl.pc_stall};
    flush_cnt_d = flush_cnt_q + {{(PERF_CNT_W-1){1'b0}}, any_flush};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
